// File: rtl/instruction_fetch.sv
// Instruction fetch front end. It owns the PC and issues one-word reads to a
// synchronous instruction memory with one cycle of read latency. Each returned
// word is paired with its PC in a two-entry output buffer, which lets decode
// stall without losing throughput. A redirect flushes everything that is
// buffered or in flight and restarts fetch at the new target.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0100_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  // instruction memory read port
  output logic [31:0] imem_address,
  output logic        imem_req,
  output logic        imem_read_write,
  input  logic [31:0] imem_data_out,
  // branch / jump redirect
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  // decode handshake
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  // Occupancy limit. Buffered entries plus the in-flight request never exceed it.
  localparam logic [2:0] FULL = 3'(BUF_DEPTH);

  logic [31:0]        pc_q, pc_d;
  logic [31:0]        req_pc_q, req_pc_d;   // PC of the request whose data returns next cycle
  logic               inflight_q, inflight_d;
  logic [1:0]         count_q, count_d;
  fetch_entry_t [1:0] buf_q, buf_d;         // entry 0 is always the head

  logic               pop, push;
  logic [2:0]         occ;
  fetch_entry_t       rsp;

  // Handshake and request issue. A request is issued only when its data is
  // sure to find a free slot after this cycle's pop, so a push never meets a
  // full buffer.
  always_comb begin
    pop      = 1'b0;
    push     = 1'b0;
    occ      = 3'd0;
    imem_req = 1'b0;
    pop      = !reset && (count_q != 2'd0) && inst_ready;
    occ      = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
    imem_req = !reset && !redirect_valid && (occ < FULL);
    // A response arriving during a redirect belongs to the old path.
    push     = inflight_q && !redirect_valid;
  end

  // Next-state logic for the PC and the request tracker.
  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = imem_req;
    if (redirect_valid) begin
      pc_d = redirect_pc & ~32'h3;
    end else if (imem_req) begin
      pc_d     = pc_q + 32'd4;   // wraps naturally at 2^32
      req_pc_d = pc_q;
    end
  end

  // Next-state logic for the output buffer. The pop shifts entry 1 down to
  // the head first, then the push lands in the first free slot, so a
  // simultaneous push and pop keeps arrival order.
  always_comb begin
    buf_d   = buf_q;
    count_d = count_q;
    rsp     = '{pc: req_pc_q, word: imem_data_out};
    if (redirect_valid) begin
      // The head is dropped, not consumed, even if decode is ready this cycle.
      count_d = 2'd0;
    end else begin
      if (pop) begin
        buf_d[0] = buf_q[1];
        count_d  = count_q - 2'd1;
      end
      if (push) begin
        buf_d[count_d[0]] = rsp;
        count_d           = count_d + 2'd1;
      end
    end
  end

  // State registers. Reset takes priority over redirect and everything else.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      buf_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      buf_q      <= buf_d;
    end
  end

  // Outputs. They are forced to their idle values while reset is high,
  // because state only clears on the first reset edge.
  always_comb begin
    imem_read_write = 1'b0;
    imem_address    = reset ? RESET_PC : pc_q;
    inst_valid      = !reset && (count_q != 2'd0);
    inst_pc         = reset ? 32'h0 : buf_q[0].pc;
    inst            = reset ? 32'h0 : buf_q[0].word;
  end

  // The issue rule guarantees that a response never arrives at a full buffer.
  a_no_push_when_full: assert property (
    @(posedge clock) disable iff (reset) push |-> (count_q != 2'd2)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch. The memory returns a fixed function of the
// address. The reference model is the architectural rule: decode sees
// consecutive PCs starting from the last reset or redirect target, and each
// PC arrives with the word that memory holds at that address.
module tb_instruction_fetch;
  localparam logic [31:0] RPC     = 32'h0100_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_ready = 1'b0;

  logic [31:0] imem_address, inst_pc, inst;
  logic [31:0] imem_data_out = '0;
  logic        imem_req, imem_read_write, inst_valid;

  logic [31:0] w_address, w_pc, w_inst;
  logic [31:0] w_data_out = '0;
  logic        w_req, w_rw, w_valid;

  int          checks = 0;
  int          passes = 0;
  logic [31:0] exp_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0100_0000) return 32'h0000_0013;
    if (a == 32'h0100_0004) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  instruction_fetch dut (
    .clock(clock), .reset(reset),
    .imem_address(imem_address), .imem_req(imem_req),
    .imem_read_write(imem_read_write), .imem_data_out(imem_data_out),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_pc(inst_pc), .inst(inst)
  );

  instruction_fetch #(.RESET_PC(WRAP_PC)) dut_w (
    .clock(clock), .reset(reset),
    .imem_address(w_address), .imem_req(w_req),
    .imem_read_write(w_rw), .imem_data_out(w_data_out),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(w_valid), .inst_ready(inst_ready),
    .inst_pc(w_pc), .inst(w_inst)
  );

  always #5 clock = ~clock;

  // synchronous memories with one cycle of read latency
  always @(posedge clock) if (imem_req) imem_data_out <= mem_word(imem_address);
  always @(posedge clock) if (w_req)    w_data_out    <= mem_word(w_address);

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++; if (inst_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", inst_valid); else passes++;
      checks++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else passes++;
      checks++; if (imem_address !== RPC) $display("FAIL reset_addr: got %h want %h", imem_address, RPC); else passes++;
      checks++; if (inst_pc !== 32'h0) $display("FAIL reset_inst_pc: got %h want 0", inst_pc); else passes++;
      checks++; if (inst !== 32'h0) $display("FAIL reset_inst: got %h want 0", inst); else passes++;
      checks++; if (imem_read_write !== 1'b0) $display("FAIL reset_rw: got %b want 0", imem_read_write); else passes++;
      step();
    end
    reset = 1'b0;
  endtask

  task automatic test_startup();
    inst_ready = 1'b1;
    exp_pc = RPC;
    @(negedge clock);
    checks++; if (imem_req !== 1'b1) $display("FAIL start_req: got %b want 1", imem_req); else passes++;
    checks++; if (imem_address !== RPC) $display("FAIL start_addr: got %h want %h", imem_address, RPC); else passes++;
    checks++; if (inst_valid !== 1'b0) $display("FAIL start_valid0: got %b want 0", inst_valid); else passes++;
    step();
    @(negedge clock);
    checks++; if (inst_valid !== 1'b0) $display("FAIL start_valid1: got %b want 0", inst_valid); else passes++;
    step();
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      checks++; if (inst_valid !== 1'b1) $display("FAIL start_stream_valid: got %b want 1", inst_valid); else passes++;
      checks++; if (inst_pc !== exp_pc) $display("FAIL start_stream_pc: got %h want %h", inst_pc, exp_pc); else passes++;
      checks++; if (inst !== mem_word(exp_pc)) $display("FAIL start_stream_inst: got %h want %h", inst, mem_word(exp_pc)); else passes++;
      exp_pc += 32'd4;
      step();
    end
  endtask

  task automatic test_stall();
    inst_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      checks++; if (inst_valid !== 1'b1) $display("FAIL stall_valid: got %b want 1", inst_valid); else passes++;
      checks++; if (inst_pc !== exp_pc) $display("FAIL stall_pc: got %h want %h", inst_pc, exp_pc); else passes++;
      checks++; if (inst !== mem_word(exp_pc)) $display("FAIL stall_inst: got %h want %h", inst, mem_word(exp_pc)); else passes++;
      checks++; if (imem_req !== 1'b0) $display("FAIL stall_req: got %b want 0", imem_req); else passes++;
      step();
    end
    inst_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++; if (inst_valid !== 1'b1) $display("FAIL resume_valid: got %b want 1", inst_valid); else passes++;
      checks++; if (inst_pc !== exp_pc) $display("FAIL resume_pc: got %h want %h", inst_pc, exp_pc); else passes++;
      exp_pc += 32'd4;
      step();
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_pc = 32'h0100_0040; inst_ready = 1'b0;
    @(negedge clock);
    checks++; if (imem_req !== 1'b0) $display("FAIL redir_req_t: got %b want 0", imem_req); else passes++;
    step();
    redirect_valid = 1'b0; inst_ready = 1'b1;
    @(negedge clock);
    checks++; if (inst_valid !== 1'b0) $display("FAIL redir_valid_t1: got %b want 0", inst_valid); else passes++;
    checks++; if (imem_req !== 1'b1) $display("FAIL redir_req_t1: got %b want 1", imem_req); else passes++;
    checks++; if (imem_address !== 32'h0100_0040) $display("FAIL redir_addr_t1: got %h want 01000040", imem_address); else passes++;
    step();
    @(negedge clock);
    checks++; if (inst_valid !== 1'b0) $display("FAIL redir_valid_t2: got %b want 0", inst_valid); else passes++;
    step();
    exp_pc = 32'h0100_0040;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++; if (inst_valid !== 1'b1) $display("FAIL redir_stream_valid: got %b want 1", inst_valid); else passes++;
      checks++; if (inst_pc !== exp_pc) $display("FAIL redir_stream_pc: got %h want %h", inst_pc, exp_pc); else passes++;
      checks++; if (inst !== mem_word(exp_pc)) $display("FAIL redir_stream_inst: got %h want %h", inst, mem_word(exp_pc)); else passes++;
      exp_pc += 32'd4;
      step();
    end
  endtask

  task automatic test_redirect_align();
    // redirect lands on a cycle where decode is popping the head
    redirect_valid = 1'b1; redirect_pc = 32'h0100_0043; inst_ready = 1'b1;
    @(negedge clock);
    checks++; if (inst_valid !== 1'b1) $display("FAIL align_pop_valid: got %b want 1", inst_valid); else passes++;
    step();
    redirect_valid = 1'b0;
    @(negedge clock);
    checks++; if (imem_address !== 32'h0100_0040) $display("FAIL align_addr: got %h want 01000040", imem_address); else passes++;
    checks++; if (inst_valid !== 1'b0) $display("FAIL align_valid_t1: got %b want 0", inst_valid); else passes++;
    step();
    step();
    exp_pc = 32'h0100_0040;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++; if (inst_valid !== 1'b1) $display("FAIL align_stream_valid: got %b want 1", inst_valid); else passes++;
      checks++; if (inst_pc !== exp_pc) $display("FAIL align_stream_pc: got %h want %h", inst_pc, exp_pc); else passes++;
      exp_pc += 32'd4;
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] tgt [3];
    tgt[0] = 32'h0100_0100; tgt[1] = 32'h0100_0200; tgt[2] = 32'h0100_0300;
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      redirect_valid = 1'b1; redirect_pc = tgt[i];
      @(negedge clock);
      checks++; if (imem_req !== 1'b0) $display("FAIL b2b_req: got %b want 0", imem_req); else passes++;
      if (i > 0) begin
        checks++; if (inst_valid !== 1'b0) $display("FAIL b2b_valid: got %b want 0", inst_valid); else passes++;
      end
      step();
    end
    redirect_valid = 1'b0;
    @(negedge clock);
    checks++; if (imem_address !== tgt[2]) $display("FAIL b2b_addr: got %h want %h", imem_address, tgt[2]); else passes++;
    step();
    @(negedge clock);
    checks++; if (inst_valid !== 1'b0) $display("FAIL b2b_valid_t2: got %b want 0", inst_valid); else passes++;
    step();
    exp_pc = tgt[2];
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++; if (inst_pc !== exp_pc || inst_valid !== 1'b1) $display("FAIL b2b_stream: got %h/%b want %h/1", inst_pc, inst_valid, exp_pc); else passes++;
      exp_pc += 32'd4;
      step();
    end
  endtask

  task automatic test_reset_mid();
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    @(negedge clock);
    checks++; if (inst_valid !== 1'b1 || imem_req !== 1'b0) $display("FAIL mid_full: got valid %b req %b want 1 0", inst_valid, imem_req); else passes++;
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0100_0500;
    @(negedge clock);
    checks++; if (inst_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", inst_valid); else passes++;
    checks++; if (imem_req !== 1'b0) $display("FAIL mid_rst_req: got %b want 0", imem_req); else passes++;
    checks++; if (imem_address !== RPC) $display("FAIL mid_rst_addr: got %h want %h", imem_address, RPC); else passes++;
    step();
    reset = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b1;
    @(negedge clock);
    checks++; if (imem_req !== 1'b1) $display("FAIL mid_after_req: got %b want 1", imem_req); else passes++;
    checks++; if (imem_address !== RPC) $display("FAIL mid_after_addr: got %h want %h", imem_address, RPC); else passes++;
    checks++; if (inst_valid !== 1'b0) $display("FAIL mid_after_valid: got %b want 0", inst_valid); else passes++;
    step();
    step();
    exp_pc = RPC;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++; if (inst_pc !== exp_pc || inst_valid !== 1'b1) $display("FAIL mid_stream: got %h/%b want %h/1", inst_pc, inst_valid, exp_pc); else passes++;
      exp_pc += 32'd4;
      step();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_w;
    reset = 1'b1; inst_ready = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    checks++; if (w_req !== 1'b1 || w_address !== WRAP_PC) $display("FAIL wrap_first_req: got %b %h want 1 %h", w_req, w_address, WRAP_PC); else passes++;
    step();
    @(negedge clock);
    checks++; if (w_valid !== 1'b0) $display("FAIL wrap_valid_t1: got %b want 0", w_valid); else passes++;
    step();
    exp_w = WRAP_PC;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++; if (w_valid !== 1'b1) $display("FAIL wrap_valid: got %b want 1", w_valid); else passes++;
      checks++; if (w_pc !== exp_w) $display("FAIL wrap_pc: got %h want %h", w_pc, exp_w); else passes++;
      checks++; if (w_inst !== mem_word(exp_w)) $display("FAIL wrap_inst: got %h want %h", w_inst, mem_word(exp_w)); else passes++;
      exp_w += 32'd4;
      step();
    end
  endtask

  task automatic test_random();
    logic        prev_stall = 1'b0;
    logic        prev_redir = 1'b0;
    logic [31:0] prev_pc = '0;
    int          pops = 0;
    for (int i = 0; i < 800; i++) begin
      redirect_valid = (i == 0) || ($urandom_range(0, 29) == 0);
      redirect_pc    = 32'h0100_0000 | ($urandom & 32'h0000_0FFF);
      inst_ready     = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      if (redirect_valid) begin
        checks++; if (imem_req !== 1'b0) $display("FAIL rnd_redir_req: got %b want 0", imem_req); else passes++;
      end else if (prev_redir) begin
        checks++; if (inst_valid !== 1'b0 || imem_address !== exp_pc) $display("FAIL rnd_restart: got %b %h want 0 %h", inst_valid, imem_address, exp_pc); else passes++;
      end else if (prev_stall) begin
        checks++; if (inst_valid !== 1'b1 || inst_pc !== prev_pc) $display("FAIL rnd_hold: got %b %h want 1 %h", inst_valid, inst_pc, prev_pc); else passes++;
      end
      if (!redirect_valid && inst_valid && inst_ready) begin
        checks++; if (inst_pc !== exp_pc) $display("FAIL rnd_pc: got %h want %h", inst_pc, exp_pc); else passes++;
        checks++; if (inst !== mem_word(exp_pc)) $display("FAIL rnd_inst: got %h want %h", inst, mem_word(exp_pc)); else passes++;
        exp_pc += 32'd4;
        pops++;
      end
      prev_stall = inst_valid && !inst_ready && !redirect_valid;
      prev_pc    = inst_pc;
      prev_redir = redirect_valid;
      if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
      step();
    end
    redirect_valid = 1'b0;
    checks++; if (pops <= 250) $display("FAIL rnd_throughput: got %0d pops want more than 250", pops); else passes++;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_stall();
    test_redirect();
    test_redirect_align();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
